// File: rtl/adc_byte_streamer.sv
`default_nettype none
// ============================================================================
// Module   : adc_byte_streamer
// Purpose  : Decimates and buffers ADC samples, streams each as two bytes over
//            a 4-phase PIO handshake (sig out, ack/flush in).
// Revision : 1.0
// ============================================================================
module adc_byte_streamer #(
    parameter int DATA_W     = 14,
    parameter int FIFO_DEPTH = 16,
    parameter int OVF_W      = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic [DATA_W-1:0]             adc_data,
    input  logic                          adc_otr,
    input  logic                          adc_strobe,
    input  logic [7:0]                    decim,
    output logic [7:0]                    to_sw_port,
    output logic [1:0]                    to_sw_sig,
    input  logic [1:0]                    to_hw_sig,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic [OVF_W-1:0]              ovf_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HI     = 3'd1,
        S_HI_REL = 3'd2,
        S_LO     = 3'd3,
        S_LO_REL = 3'd4
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [7:0]          r_port, w_port_nxt;
    logic [1:0]          r_sig, w_sig_nxt;
    logic [7:0]          r_lo;
    logic [AW-1:0]       r_wr, r_rd;
    logic [LW-1:0]       r_level;
    logic [7:0]          r_dcnt;
    logic                r_ovf;
    logic [OVF_W-1:0]    r_ovf_cnt;
    logic [DATA_W:0]     r_mem [FIFO_DEPTH];

    logic                w_ack, w_flush, w_pop, w_push, w_drop;
    logic                w_keep, w_empty, w_full;
    logic [7:0]          w_dmax;
    logic [DATA_W:0]     w_head;
    logic [5:0]          w_hi6;
    logic [7:0]          w_hi_byte;

    assign w_ack   = to_hw_sig[0];
    assign w_flush = to_hw_sig[1];
    assign w_dmax  = (decim == 8'd0) ? 8'd0 : decim - 8'd1;
    assign w_keep  = enable & adc_strobe & (r_dcnt == 8'd0);
    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == LW'(FIFO_DEPTH));
    assign w_push  = w_keep & ~w_flush & (~w_full | w_pop);
    assign w_drop  = w_keep & ~w_flush & w_full & ~w_pop;
    assign w_head  = r_mem[r_rd];

    // Narrow samples leave the upper high-byte data bits zero.
    generate
        if (DATA_W >= 14) begin : g_hi_full
            assign w_hi6 = w_head[13:8];
        end else begin : g_hi_pad
            assign w_hi6 = {{(14-DATA_W){1'b0}}, w_head[DATA_W-1:8]};
        end
    endgenerate

    assign w_hi_byte = {w_head[DATA_W], 1'b0, w_hi6};

    always_comb begin
        w_state_nxt = r_state;
        w_port_nxt  = r_port;
        w_sig_nxt   = r_sig;
        w_pop       = 1'b0;
        if (w_flush) begin
            w_state_nxt = S_IDLE;
            w_sig_nxt   = 2'b00;
        end else begin
            case (r_state)
                S_IDLE: if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_HI;
                    w_port_nxt  = w_hi_byte;
                    w_sig_nxt   = 2'b01;
                end
                S_HI: if (w_ack) begin
                    w_state_nxt = S_HI_REL;
                    w_sig_nxt   = 2'b00;
                end
                S_HI_REL: if (!w_ack) begin
                    w_state_nxt = S_LO;
                    w_port_nxt  = r_lo;
                    w_sig_nxt   = 2'b10;
                end
                S_LO: if (w_ack) begin
                    w_state_nxt = S_LO_REL;
                    w_sig_nxt   = 2'b00;
                end
                S_LO_REL: if (!w_ack) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = S_HI;
                        w_port_nxt  = w_hi_byte;
                        w_sig_nxt   = 2'b01;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_sig_nxt   = 2'b00;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_port    <= '0;
            r_sig     <= '0;
            r_lo      <= '0;
            r_wr      <= '0;
            r_rd      <= '0;
            r_level   <= '0;
            r_dcnt    <= '0;
            r_ovf     <= 1'b0;
            r_ovf_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_port  <= w_port_nxt;
            r_sig   <= w_sig_nxt;
            if (w_pop)
                r_lo <= w_head[7:0];

            if (!enable)
                r_dcnt <= '0;
            else if (adc_strobe)
                r_dcnt <= (r_dcnt >= w_dmax) ? 8'd0 : r_dcnt + 8'd1;

            if (w_flush) begin
                r_wr      <= '0;
                r_rd      <= '0;
                r_level   <= '0;
                r_ovf     <= 1'b0;
                r_ovf_cnt <= '0;
            end else begin
                if (w_push)
                    r_wr <= r_wr + AW'(1);
                if (w_pop)
                    r_rd <= r_rd + AW'(1);
                if (w_push && !w_pop)
                    r_level <= r_level + LW'(1);
                else if (w_pop && !w_push)
                    r_level <= r_level - LW'(1);
                if (w_drop) begin
                    r_ovf <= 1'b1;
                    if (r_ovf_cnt != '1)
                        r_ovf_cnt <= r_ovf_cnt + OVF_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr] <= {adc_otr, adc_data};
    end

    assign to_sw_port = r_port;
    assign to_sw_sig  = r_sig;
    assign fifo_level = r_level;
    assign overflow   = r_ovf;
    assign ovf_count  = r_ovf_cnt;

endmodule
`default_nettype wire

// File: tb/tb_adc_byte_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_byte_streamer
// Purpose  : Directed self-checking bench for adc_byte_streamer.
// Revision : 1.0
// ============================================================================
module tb_adc_byte_streamer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [13:0] adc_data;
    logic        adc_otr;
    logic        adc_strobe;
    logic [7:0]  decim;
    logic [7:0]  to_sw_port;
    logic [1:0]  to_sw_sig;
    logic [1:0]  to_hw_sig;
    logic [4:0]  fifo_level;
    logic        overflow;
    logic [15:0] ovf_count;

    int n_cmp = 0;
    int n_bad = 0;

    adc_byte_streamer #(.DATA_W(14), .FIFO_DEPTH(16), .OVF_W(16)) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .adc_data   (adc_data),
        .adc_otr    (adc_otr),
        .adc_strobe (adc_strobe),
        .decim      (decim),
        .to_sw_port (to_sw_port),
        .to_sw_sig  (to_sw_sig),
        .to_hw_sig  (to_hw_sig),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .ovf_count  (ovf_count)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sig(input string tag, input logic [1:0] code);
        int n = 0;
        while (to_sw_sig !== code && n < 50) begin
            tick();
            n++;
        end
        chk_eq(tag, {30'd0, to_sw_sig}, {30'd0, code});
    endtask

    task automatic strobe(input logic [13:0] d, input logic otr);
        adc_data   = d;
        adc_otr    = otr;
        adc_strobe = 1'b1;
        tick();
        adc_strobe = 1'b0;
    endtask

    task automatic xfer(input string tag, input logic [7:0] hi, input logic [7:0] lo);
        wait_sig({tag, "_sig_hi"}, 2'b01);
        chk_eq({tag, "_hi"}, {24'd0, to_sw_port}, {24'd0, hi});
        to_hw_sig = 2'b01;
        wait_sig({tag, "_rel1"}, 2'b00);
        to_hw_sig = 2'b00;
        wait_sig({tag, "_sig_lo"}, 2'b10);
        chk_eq({tag, "_lo"}, {24'd0, to_sw_port}, {24'd0, lo});
        to_hw_sig = 2'b01;
        wait_sig({tag, "_rel2"}, 2'b00);
        to_hw_sig = 2'b00;
        tick();
    endtask

    initial begin
        reset_n    = 1'b0;
        enable     = 1'b0;
        adc_data   = '0;
        adc_otr    = 1'b0;
        adc_strobe = 1'b0;
        decim      = 8'd1;
        to_hw_sig  = 2'b00;
        #23;
        chk_eq("rst_sig",   {30'd0, to_sw_sig}, 32'd0);
        chk_eq("rst_port",  {24'd0, to_sw_port}, 32'd0);
        chk_eq("rst_level", {27'd0, fifo_level}, 32'd0);
        chk_eq("rst_ovf",   {15'd0, overflow, ovf_count}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        enable = 1'b1;

        // Single sample, cycle-exact
        strobe(14'h2A5C, 1'b0);
        chk_eq("single_level1", {27'd0, fifo_level}, 32'd1);
        tick();
        chk_eq("single_sig_hi", {30'd0, to_sw_sig}, 32'd1);
        chk_eq("single_hi",     {24'd0, to_sw_port}, 32'h2A);
        to_hw_sig = 2'b01;
        tick();
        chk_eq("single_rel1",   {30'd0, to_sw_sig}, 32'd0);
        chk_eq("single_hold",   {24'd0, to_sw_port}, 32'h2A);
        to_hw_sig = 2'b00;
        tick();
        chk_eq("single_sig_lo", {30'd0, to_sw_sig}, 32'd2);
        chk_eq("single_lo",     {24'd0, to_sw_port}, 32'h5C);
        to_hw_sig = 2'b01;
        tick();
        to_hw_sig = 2'b00;
        tick();
        chk_eq("single_end_sig", {30'd0, to_sw_sig}, 32'd0);
        chk_eq("single_end_lvl", {27'd0, fifo_level}, 32'd0);

        // Out-of-range sample
        strobe(14'h3FFF, 1'b1);
        xfer("otr", 8'hBF, 8'hFF);

        // Overflow: 20 back-to-back kept strobes, ack held low
        for (int i = 0; i < 20; i++) begin
            adc_data   = 14'(i + 14'h0100);
            adc_otr    = 1'b0;
            adc_strobe = 1'b1;
            tick();
        end
        adc_strobe = 1'b0;
        chk_eq("ovf_level", {27'd0, fifo_level}, 32'd16);
        chk_eq("ovf_flag",  {31'd0, overflow}, 32'd1);
        chk_eq("ovf_count", {16'd0, ovf_count}, 32'd3);
        chk_eq("ovf_sig",   {30'd0, to_sw_sig}, 32'd1);
        chk_eq("ovf_hi",    {24'd0, to_sw_port}, 32'h01);

        // Flush while in HI with queued samples
        to_hw_sig = 2'b10;
        tick();
        to_hw_sig = 2'b00;
        chk_eq("flush_sig",   {30'd0, to_sw_sig}, 32'd0);
        chk_eq("flush_level", {27'd0, fifo_level}, 32'd0);
        chk_eq("flush_ovf",   {31'd0, overflow}, 32'd0);
        chk_eq("flush_cnt",   {16'd0, ovf_count}, 32'd0);
        tick();
        chk_eq("flush_idle",  {30'd0, to_sw_sig}, 32'd0);

        // Decimation by 4: samples 0, 4, 8 survive
        decim = 8'd4;
        for (int i = 0; i < 12; i++) strobe(14'(i), 1'b0);
        chk_eq("dec_level", {27'd0, fifo_level}, 32'd2);
        xfer("dec0", 8'h00, 8'h00);
        xfer("dec4", 8'h00, 8'h04);
        xfer("dec8", 8'h00, 8'h08);
        chk_eq("dec_empty", {27'd0, fifo_level}, 32'd0);

        // decim=0 keeps every strobe
        enable = 1'b0;
        tick();
        enable = 1'b1;
        decim  = 8'd0;
        strobe(14'h0121, 1'b0);
        strobe(14'h0222, 1'b0);
        strobe(14'h0323, 1'b0);
        xfer("d0a", 8'h01, 8'h21);
        xfer("d0b", 8'h02, 8'h22);
        xfer("d0c", 8'h03, 8'h23);

        // Asynchronous reset mid-transfer (sig=10, samples queued)
        decim = 8'd1;
        strobe(14'h1234, 1'b0);
        strobe(14'h0555, 1'b0);
        strobe(14'h0666, 1'b0);
        wait_sig("ar_sig_hi", 2'b01);
        to_hw_sig = 2'b01;
        wait_sig("ar_rel", 2'b00);
        to_hw_sig = 2'b00;
        wait_sig("ar_sig_lo", 2'b10);
        #2;
        reset_n = 1'b0;
        #1;
        chk_eq("ar_sig",   {30'd0, to_sw_sig}, 32'd0);
        chk_eq("ar_port",  {24'd0, to_sw_port}, 32'd0);
        chk_eq("ar_level", {27'd0, fifo_level}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        strobe(14'h0ABC, 1'b0);
        xfer("post_rst", 8'h0A, 8'hBC);
        chk_eq("post_rst_lvl", {27'd0, fifo_level}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
